// File: rtl/dpb_ring_pkg.sv
// Shared types and widths for the DPB frame-ring slot scheduler.
package dpb_ring_pkg;

    localparam int DPB_SLOT_AW = 4;
    localparam int DPB_WORD_AW = 7;

    typedef enum logic {
        WR_IDLE,
        WR_FILL
    } wr_state_t;

endpackage

// File: rtl/dpb_ring_stats.sv
// Ring statistics: saturating stall-while-full counter and peak occupancy.
module dpb_ring_stats #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [CNT_W-1:0] count_nxt,
    output logic [15:0]      stall_cnt,
    output logic [CNT_W-1:0] peak_count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            peak_count <= '0;
        end else begin
            if (stall && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            // Track the next count so the peak lines up with o_slot_count.
            if (count_nxt > peak_count)
                peak_count <= count_nxt;
        end
    end

endmodule

// File: rtl/dpb_ring_slot_ctrl.sv
// Slot scheduler for the 16-slot DPB frame ring (producer grant, FIFO consumer).
// Define DPB_RING_STATS_EN to build the stall/peak statistics outputs.
module dpb_ring_slot_ctrl
    import dpb_ring_pkg::*;
#(
    parameter int SLOT_AW = DPB_SLOT_AW,
    parameter int WORD_AW = DPB_WORD_AW
) (
    input  logic                       i_clk50m,
    input  logic                       i_rst_n,
    input  logic                       i_wr_slot_req,
    output logic                       o_wr_slot_gnt,
    output logic [SLOT_AW-1:0]         o_wr_slot_idx,
    output logic [SLOT_AW+WORD_AW-1:0] o_wr_base_addr,
    input  logic                       i_wr_slot_commit,
    input  logic                       i_wr_slot_abort,
    output logic                       o_rd_slot_valid,
    output logic [SLOT_AW-1:0]         o_rd_slot_idx,
    output logic [SLOT_AW+WORD_AW-1:0] o_rd_base_addr,
    input  logic                       i_rd_slot_release,
    output logic [SLOT_AW:0]           o_slot_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_err,
    output logic [15:0]                o_stall_cnt,
    output logic [SLOT_AW:0]           o_peak_count
);

    localparam logic [SLOT_AW:0]   DEPTH_C = (SLOT_AW+1)'(1 << SLOT_AW);
    localparam logic [SLOT_AW:0]   ONE_C   = (SLOT_AW+1)'(1);
    localparam logic [SLOT_AW-1:0] PTR_ONE = SLOT_AW'(1);

    wr_state_t          state;
    logic [SLOT_AW-1:0] wr_ptr;
    logic [SLOT_AW-1:0] rd_ptr;
    logic [SLOT_AW:0]   count;
    logic [SLOT_AW:0]   count_nxt;
    logic               full_now;
    logic               do_commit;
    logic               do_abort;
    logic               do_release;
    logic               bad_op;

    assign full_now   = (count == DEPTH_C);
    assign do_abort   = (state == WR_FILL) && i_wr_slot_abort;
    assign do_commit  = (state == WR_FILL) && i_wr_slot_commit
                        && !i_wr_slot_abort;
    assign do_release = i_rd_slot_release && (count != '0);
    assign bad_op     = ((i_wr_slot_commit || i_wr_slot_abort)
                         && (state != WR_FILL))
                        || (i_rd_slot_release && (count == '0));

    always_comb begin
        count_nxt = count;
        if (do_commit && !do_release)
            count_nxt = count + ONE_C;
        else if (!do_commit && do_release)
            count_nxt = count - ONE_C;
    end

    always_ff @(posedge i_clk50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= WR_IDLE;
            o_wr_slot_gnt   <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            o_rd_slot_valid <= 1'b0;
            o_full          <= 1'b0;
            o_empty         <= 1'b1;
            o_err           <= 1'b0;
        end else begin
            o_wr_slot_gnt <= 1'b0;
            unique case (state)
                WR_IDLE: begin
                    if (i_wr_slot_req && !full_now) begin
                        state         <= WR_FILL;
                        o_wr_slot_gnt <= 1'b1;
                    end
                end
                WR_FILL: begin
                    // Abort leaves wr_ptr alone so the same slot is re-granted.
                    if (do_abort) begin
                        state <= WR_IDLE;
                    end else if (do_commit) begin
                        wr_ptr <= wr_ptr + PTR_ONE;
                        state  <= WR_IDLE;
                    end
                end
                default: state <= WR_IDLE;
            endcase
            if (do_release)
                rd_ptr <= rd_ptr + PTR_ONE;
            count           <= count_nxt;
            o_rd_slot_valid <= (count_nxt != '0);
            o_full          <= (count_nxt == DEPTH_C);
            o_empty         <= (count_nxt == '0);
            if (bad_op)
                o_err <= 1'b1;
        end
    end

    assign o_wr_slot_idx  = wr_ptr;
    assign o_rd_slot_idx  = rd_ptr;
    assign o_slot_count   = count;
    assign o_wr_base_addr = {wr_ptr, {WORD_AW{1'b0}}};
    assign o_rd_base_addr = {rd_ptr, {WORD_AW{1'b0}}};

`ifdef DPB_RING_STATS_EN
    logic stall;

    assign stall = (state == WR_IDLE) && i_wr_slot_req && full_now;

    dpb_ring_stats #(
        .CNT_W      (SLOT_AW + 1)
    ) u_stats (
        .clk        (i_clk50m),
        .rst_n      (i_rst_n),
        .stall      (stall),
        .count_nxt  (count_nxt),
        .stall_cnt  (o_stall_cnt),
        .peak_count (o_peak_count)
    );
`else
    assign o_stall_cnt  = '0;
    assign o_peak_count = '0;
`endif

endmodule

// File: tb/tb_dpb_ring_slot_ctrl.sv
// Scoreboard bench for dpb_ring_slot_ctrl: grant and read-order queues.
module tb_dpb_ring_slot_ctrl;
    import dpb_ring_pkg::*;

    localparam int SAW = DPB_SLOT_AW;
    localparam int WAW = DPB_WORD_AW;
    localparam int DEPTH = 1 << SAW;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req;
    logic               gnt;
    logic [SAW-1:0]     wr_idx;
    logic [SAW+WAW-1:0] wr_base;
    logic               commit;
    logic               abort;
    logic               rd_valid;
    logic [SAW-1:0]     rd_idx;
    logic [SAW+WAW-1:0] rd_base;
    logic               rel;
    logic [SAW:0]       slot_count;
    logic               full;
    logic               empty;
    logic               err;
    logic [15:0]        stall_cnt;
    logic [SAW:0]       peak_count;

    dpb_ring_slot_ctrl dut (
        .i_clk50m          (clk),
        .i_rst_n           (rst_n),
        .i_wr_slot_req     (req),
        .o_wr_slot_gnt     (gnt),
        .o_wr_slot_idx     (wr_idx),
        .o_wr_base_addr    (wr_base),
        .i_wr_slot_commit  (commit),
        .i_wr_slot_abort   (abort),
        .o_rd_slot_valid   (rd_valid),
        .o_rd_slot_idx     (rd_idx),
        .o_rd_base_addr    (rd_base),
        .i_rd_slot_release (rel),
        .o_slot_count      (slot_count),
        .o_full            (full),
        .o_empty           (empty),
        .o_err             (err),
        .o_stall_cnt       (stall_cnt),
        .o_peak_count      (peak_count)
    );

    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int m_count = 0;
    logic [SAW-1:0] m_wr_ptr = '0;
    logic [SAW-1:0] gnt_q[$];
    logic [SAW-1:0] rd_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_occ(input string tag);
        check({tag, "_count"}, int'(slot_count), m_count);
        check({tag, "_empty"}, int'(empty), int'(m_count == 0));
        check({tag, "_full"}, int'(full), int'(m_count == DEPTH));
        check({tag, "_valid"}, int'(rd_valid), int'(m_count != 0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        gnt_q.delete();
        rd_q.delete();
        m_count  = 0;
        m_wr_ptr = '0;
    endtask

    task automatic request();
        logic [SAW-1:0] exp;
        int got;
        int lat;
        gnt_q.push_back(m_wr_ptr);
        req = 1'b1;
        got = 0;
        lat = -1;
        for (int i = 0; i < 8 && got == 0; i++) begin
            tick();
            if (gnt) begin
                got = 1;
                lat = i;
            end
        end
        req = 1'b0;
        exp = gnt_q.pop_front();
        check("gnt_seen", got, 1);
        if (got == 1) begin
            check("gnt_lat", lat, 0);
            check("gnt_idx", int'(wr_idx), int'(exp));
            check("wr_base", int'(wr_base), int'({exp, {WAW{1'b0}}}));
        end
        tick();
        check("gnt_pulse", int'(gnt), 0);
    endtask

    task automatic do_commit();
        rd_q.push_back(m_wr_ptr);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        m_wr_ptr = m_wr_ptr + 1'b1;
        m_count++;
        check_occ("commit");
    endtask

    task automatic do_release();
        logic [SAW-1:0] exp;
        exp = rd_q.pop_front();
        check("rd_idx", int'(rd_idx), int'(exp));
        check("rd_base", int'(rd_base), int'({exp, {WAW{1'b0}}}));
        rel = 1'b1;
        tick();
        rel = 1'b0;
        m_count--;
        check_occ("release");
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SAW-1:0] exp;
        int saw;
        req    = 1'b0;
        commit = 1'b0;
        abort  = 1'b0;
        rel    = 1'b0;
        do_reset();

        // reset state
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_valid", int'(rd_valid), 0);
        check("rst_count", int'(slot_count), 0);
        check("rst_err", int'(err), 0);
        check("rst_gnt", int'(gnt), 0);

        // single grant/commit/release
        request();
        do_commit();
        do_release();

        // fill to full, then stall and wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            request();
            do_commit();
        end
        gnt_q.push_back(m_wr_ptr);
        req = 1'b1;
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (gnt) saw = 1;
        end
        check("full_no_gnt", saw, 0);
`ifdef DPB_RING_STATS_EN
        check("stall_cnt", int'(stall_cnt), 10);
`endif
        exp = rd_q.pop_front();
        check("rd_idx_full", int'(rd_idx), int'(exp));
        rel = 1'b1;
        tick();
        rel = 1'b0;
        m_count--;
        check_occ("drop");
        check("gnt_early", int'(gnt), 0);
        tick();
        req = 1'b0;
        exp = gnt_q.pop_front();
        check("gnt_wrap", int'(gnt), 1);
        check("gnt_wrap_idx", int'(wr_idx), int'(exp));
        do_commit();

        // down to three, then commit and release together
        for (int i = 0; i < 13; i++) do_release();
        request();
        exp = rd_q.pop_front();
        check("rd_idx_pre", int'(rd_idx), int'(exp));
        rd_q.push_back(m_wr_ptr);
        commit = 1'b1;
        rel    = 1'b1;
        tick();
        commit = 1'b0;
        rel    = 1'b0;
        m_wr_ptr = m_wr_ptr + 1'b1;
        check_occ("both");
        check("rd_idx_post", int'(rd_idx), int'(rd_q[0]));
        request();
        do_commit();

        // abort at slot 5 reuses the index
        while (m_wr_ptr != 4'd5) begin
            request();
            do_commit();
        end
        request();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_occ("abort");
        request();
        commit = 1'b1;
        abort  = 1'b1;
        tick();
        commit = 1'b0;
        abort  = 1'b0;
        check_occ("abort_wins");
        request();
        do_commit();
        check("err_clean", int'(err), 0);

        // drain, then underflow release
        while (rd_q.size() > 0) do_release();
        rel = 1'b1;
        tick();
        rel = 1'b0;
        check("err_set", int'(err), 1);
        check("err_count", int'(slot_count), 0);
        tick();
        tick();
        check("err_sticky", int'(err), 1);
        request();
        do_commit();
        check("err_sticky2", int'(err), 1);

`ifdef DPB_RING_STATS_EN
        check("peak", int'(peak_count), DEPTH);
`else
        check("stall_tied", int'(stall_cnt), 0);
        check("peak_tied", int'(peak_count), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
